// File: rtl/id_ex_operand_stage_if.sv
// Bundle of ID-side, forwarding and EX-side signals for the ID/EX operand stage.
// The master drives the ID/forwarding inputs; the slave (the stage) drives the ALU-facing outputs.
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              stall_i;
  logic              flush_i;
  logic              id_valid_i;
  logic [DATA_W-1:0] id_rs_data_i;
  logic [DATA_W-1:0] id_rt_data_i;
  logic [DATA_W-1:0] id_imm_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic [REG_AW-1:0] id_rd_i;
  logic [3:0]        id_alu_ctrl_i;
  logic [2:0]        id_bonus_ctrl_i;
  logic              id_alu_src_i;
  logic              id_reg_write_i;
  logic              id_mem_read_i;
  logic              id_mem_write_i;
  logic              id_mem_to_reg_i;
  logic              exmem_reg_write_i;
  logic [REG_AW-1:0] exmem_rd_i;
  logic [DATA_W-1:0] exmem_result_i;
  logic              memwb_reg_write_i;
  logic [REG_AW-1:0] memwb_rd_i;
  logic [DATA_W-1:0] memwb_data_i;
  logic [DATA_W-1:0] src1_o;
  logic [DATA_W-1:0] src2_o;
  logic [3:0]        alu_ctrl_o;
  logic [2:0]        bonus_ctrl_o;
  logic [DATA_W-1:0] ex_store_data_o;
  logic [REG_AW-1:0] ex_rd_o;
  logic              ex_valid_o;
  logic              ex_reg_write_o;
  logic              ex_mem_read_o;
  logic              ex_mem_write_o;
  logic              ex_mem_to_reg_o;
  logic              load_use_o;

  modport master (
    output stall_i, flush_i, id_valid_i, id_rs_data_i, id_rt_data_i, id_imm_i,
           id_rs_i, id_rt_i, id_rd_i, id_alu_ctrl_i, id_bonus_ctrl_i, id_alu_src_i,
           id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i,
           exmem_reg_write_i, exmem_rd_i, exmem_result_i,
           memwb_reg_write_i, memwb_rd_i, memwb_data_i,
    input  src1_o, src2_o, alu_ctrl_o, bonus_ctrl_o, ex_store_data_o, ex_rd_o,
           ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
           ex_mem_to_reg_o, load_use_o
  );

  modport slave (
    input  stall_i, flush_i, id_valid_i, id_rs_data_i, id_rt_data_i, id_imm_i,
           id_rs_i, id_rt_i, id_rd_i, id_alu_ctrl_i, id_bonus_ctrl_i, id_alu_src_i,
           id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i,
           exmem_reg_write_i, exmem_rd_i, exmem_result_i,
           memwb_reg_write_i, memwb_rd_i, memwb_data_i,
    output src1_o, src2_o, alu_ctrl_o, bonus_ctrl_o, ex_store_data_o, ex_rd_o,
           ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
           ex_mem_to_reg_o, load_use_o
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use bubble insertion.
// Operand outputs are combinational from the registered fields plus the live forwarding buses.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  id_ex_operand_stage_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [3:0]        alu_ctrl;
    logic [2:0]        bonus_ctrl;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } stage_t;

  stage_t            stage_q;
  stage_t            stage_d;
  stage_t            id_fields;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;
  logic              load_use;

  always_comb begin
    id_fields            = '0;
    id_fields.valid      = 1'b1;
    id_fields.rs_data    = bus.id_rs_data_i;
    id_fields.rt_data    = bus.id_rt_data_i;
    id_fields.imm        = bus.id_imm_i;
    id_fields.rs         = bus.id_rs_i;
    id_fields.rt         = bus.id_rt_i;
    id_fields.rd         = bus.id_rd_i;
    id_fields.alu_ctrl   = bus.id_alu_ctrl_i;
    id_fields.bonus_ctrl = bus.id_bonus_ctrl_i;
    id_fields.alu_src    = bus.id_alu_src_i;
    id_fields.reg_write  = bus.id_reg_write_i;
    id_fields.mem_read   = bus.id_mem_read_i;
    id_fields.mem_write  = bus.id_mem_write_i;
    id_fields.mem_to_reg = bus.id_mem_to_reg_i;
  end

  // EX/MEM is the younger producer, so it is tested first; register 0 never forwards.
  always_comb begin
    fwd_rs = stage_q.rs_data;
    if (bus.exmem_reg_write_i && (bus.exmem_rd_i != '0) && (bus.exmem_rd_i == stage_q.rs))
      fwd_rs = bus.exmem_result_i;
    else if (bus.memwb_reg_write_i && (bus.memwb_rd_i != '0) && (bus.memwb_rd_i == stage_q.rs))
      fwd_rs = bus.memwb_data_i;
  end

  always_comb begin
    fwd_rt = stage_q.rt_data;
    if (bus.exmem_reg_write_i && (bus.exmem_rd_i != '0) && (bus.exmem_rd_i == stage_q.rt))
      fwd_rt = bus.exmem_result_i;
    else if (bus.memwb_reg_write_i && (bus.memwb_rd_i != '0) && (bus.memwb_rd_i == stage_q.rt))
      fwd_rt = bus.memwb_data_i;
  end

  assign load_use = stage_q.valid && stage_q.mem_read && (stage_q.rd != '0) && bus.id_valid_i &&
                    ((stage_q.rd == bus.id_rs_i) || (stage_q.rd == bus.id_rt_i));

  // A stall refreshes the operand data with the forwarded values so the forward
  // survives the producer leaving the pipeline.
  always_comb begin
    stage_d = stage_q;
    if (bus.flush_i) begin
      stage_d = '0;
    end else if (bus.stall_i) begin
      stage_d.rs_data = fwd_rs;
      stage_d.rt_data = fwd_rt;
    end else if (load_use) begin
      stage_d = '0;
    end else if (bus.id_valid_i) begin
      stage_d = id_fields;
    end else begin
      stage_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign bus.src1_o          = fwd_rs;
  assign bus.src2_o          = stage_q.alu_src ? stage_q.imm : fwd_rt;
  assign bus.ex_store_data_o = fwd_rt;
  assign bus.alu_ctrl_o      = stage_q.alu_ctrl;
  assign bus.bonus_ctrl_o    = stage_q.bonus_ctrl;
  assign bus.ex_rd_o         = stage_q.rd;
  assign bus.ex_valid_o      = stage_q.valid;
  assign bus.ex_reg_write_o  = stage_q.reg_write;
  assign bus.ex_mem_read_o   = stage_q.mem_read;
  assign bus.ex_mem_write_o  = stage_q.mem_write;
  assign bus.ex_mem_to_reg_o = stage_q.mem_to_reg;
  assign bus.load_use_o      = load_use;

endmodule
